// File: rtl/oled_frame_tx_pkg.sv
// rtl/oled_frame_tx_pkg.sv - shared constants and FSM encoding for the OLED frame transmitter
//
// Purpose : state encoding, frame size and framebuffer address width shared by
//           oled_frame_tx and its bench.
// Contents: FRAME_BYTES_DEF, ADDR_W, state_t, is_hi_phase()
package oled_frame_tx_pkg;

  // Bytes per frame (128x64 mono panel, one byte per 8 vertical pixels).
  localparam int unsigned FRAME_BYTES_DEF = 1024;

  // Framebuffer address width; must cover FRAME_BYTES_DEF-1.
  localparam int unsigned ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD_LO  = 3'd1,
    CMD_HI  = 3'd2,
    DATA_LO = 3'd3,
    DATA_HI = 3'd4,
    DONE    = 3'd5
  } state_t;

  // The strobe is high exactly in the second half of every byte slot.
  function automatic logic is_hi_phase(input state_t s);
    return (s == CMD_HI) || (s == DATA_HI);
  endfunction

endpackage

// File: rtl/oled_phase_timer.sv
// rtl/oled_phase_timer.sv - HALF-cycle down counter with terminal pulse
//
// Purpose : measures one oled_clk phase. A restart loads HALF-1; the counter
//           then counts down and o_tc is high while it sits at zero, so a
//           state entered together with a restart lasts exactly HALF cycles.
// Ports   : clock     - system clock
//           reset_n   - asynchronous active-low reset
//           i_restart - reload the counter (asserted on each phase entry)
//           o_tc      - terminal count, current phase ends this cycle
module oled_phase_timer #(
  parameter int unsigned HALF = 2  // legal range 1..255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_restart,
  output logic o_tc
);

  localparam logic [7:0] LOAD_VAL = 8'(HALF - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/oled_frame_tx.sv
// rtl/oled_frame_tx.sv - streams one command byte plus a framebuffer to an OLED byte bus
//
// Purpose : on start, sends cmd_byte with oled_dc=0, then FRAME_BYTES bytes
//           read from the framebuffer with oled_dc=1. Every byte occupies HALF
//           cycles with oled_clk low followed by HALF cycles with oled_clk high.
// Ports   : clock, reset_n       - system clock, asynchronous active-low reset
//           start, cmd_byte      - frame request (IDLE only) and its command byte
//           fb_addr, fb_data     - framebuffer read port, one-cycle read latency
//           oled_clk, oled_dc,
//           oled_data            - byte strobe, data/command select, byte bus
//           busy, done           - frame in progress, end-of-frame pulse
module oled_frame_tx
  import oled_frame_tx_pkg::*;
#(
  parameter int unsigned HALF        = 2,  // legal range 1..255
  parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        cmd_byte,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_data,
  output logic              oled_clk,
  output logic              oled_dc,
  output logic [7:0]        oled_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_BYTES - 1);

  state_t            r_state;
  state_t            w_next;
  logic              w_restart;
  logic              w_load_cmd;
  logic              w_load_data;
  logic              w_tc;

  logic              r_dc;
  logic [7:0]        r_data;
  logic [ADDR_W-1:0] r_addr;      // index of the next data byte to present
  logic [ADDR_W-1:0] r_byte_idx;  // index of the data byte currently on the bus

  oled_phase_timer #(
    .HALF (HALF)
  ) u_phase_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_restart (w_restart),
    .o_tc      (w_tc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // w_load_* mark the LO entries, the only points where the bus may change.
  always_comb begin
    w_next      = r_state;
    w_restart   = 1'b0;
    w_load_cmd  = 1'b0;
    w_load_data = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next     = CMD_LO;
          w_restart  = 1'b1;
          w_load_cmd = 1'b1;
        end
      end
      CMD_LO: begin
        if (w_tc) begin
          w_next    = CMD_HI;
          w_restart = 1'b1;
        end
      end
      CMD_HI: begin
        if (w_tc) begin
          w_next      = DATA_LO;
          w_restart   = 1'b1;
          w_load_data = 1'b1;
        end
      end
      DATA_LO: begin
        if (w_tc) begin
          w_next    = DATA_HI;
          w_restart = 1'b1;
        end
      end
      DATA_HI: begin
        if (w_tc) begin
          if (r_byte_idx == LAST_IDX) begin
            // No restart: the timer stays at zero through DONE and IDLE.
            w_next = DONE;
          end else begin
            w_next      = DATA_LO;
            w_restart   = 1'b1;
            w_load_data = 1'b1;
          end
        end
      end
      DONE: begin
        // start is deliberately not looked at here.
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // fb_addr has been stable for at least one cycle before each DATA_LO entry,
  // so fb_data already reflects it when it is captured onto the bus.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dc       <= 1'b0;
      r_data     <= '0;
      r_addr     <= '0;
      r_byte_idx <= '0;
    end else begin
      if (w_load_cmd) begin
        r_dc       <= 1'b0;
        r_data     <= cmd_byte;
        r_addr     <= '0;
        r_byte_idx <= '0;
      end
      if (w_load_data) begin
        r_dc       <= 1'b1;
        r_data     <= fb_data;
        r_byte_idx <= r_addr;
        // After the last byte the address parks at 0 for the next frame.
        r_addr     <= (r_addr == LAST_IDX) ? '0 : r_addr + ADDR_W'(1);
      end
    end
  end

  assign fb_addr   = r_addr;
  assign oled_dc   = r_dc;
  assign oled_data = r_data;
  assign oled_clk  = is_hi_phase(r_state);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);

endmodule

// File: doc/oled_frame_tx.md
OLED_FRAME_TX -- requirements
Module: oled_frame_tx

Interface
REQ-001 Parameter: HALF, default 2, number of clock cycles per oled_clk phase (legal range 1..255).
REQ-002 Parameter: FRAME_BYTES, default 1024, number of data bytes per frame.
REQ-003 Port: clock  input  1  system clock; all logic is on its rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  request to transmit one frame; sampled only in IDLE.
REQ-006 Port: cmd_byte  input  8  command/tone byte, sent with oled_dc=0 ahead of the frame.
REQ-007 Port: fb_addr  output  10  framebuffer read address.
REQ-008 Port: fb_data  input  8  framebuffer read data, valid one clock after fb_addr.
REQ-009 Port: oled_clk  output  1  byte strobe; the receiver samples oled_dc and oled_data on its rising edge.
REQ-010 Port: oled_dc  output  1  0 = command byte (resets receiver address), 1 = pixel data byte.
REQ-011 Port: oled_data  output  8  byte on the bus.
REQ-012 Port: busy  output  1  high from the cycle after start is accepted until done.
REQ-013 Port: done  output  1  single-cycle pulse at end of frame.

Function
REQ-014 The FSM SHALL have states IDLE, CMD_LO, CMD_HI, DATA_LO, DATA_HI, DONE.
REQ-015 In IDLE with start=1, the block SHALL latch cmd_byte, enter CMD_LO next cycle, set busy=1, oled_dc=0, oled_data=latched cmd_byte, fb_addr=0.
REQ-016 Each byte SHALL occupy exactly 2*HALF cycles: HALF cycles with oled_clk=0 (LO state), then HALF cycles with oled_clk=1 (HI state).
REQ-017 oled_dc and oled_data SHALL change only on entry to a LO state and SHALL stay stable through the following HI state.
REQ-018 CMD_HI SHALL go to DATA_LO; the first DATA_LO SHALL present oled_dc=1, oled_data=fb_data for address 0.
REQ-019 fb_addr SHALL hold the index of the next data byte for at least one cycle before the LO entry that consumes it; it SHALL increment on each DATA_LO entry.
REQ-020 The byte index SHALL count 0..FRAME_BYTES-1 without wrap; after DATA_HI of byte FRAME_BYTES-1 the FSM SHALL go to DONE.
REQ-021 DONE SHALL last one cycle with done=1, busy=0 on the following cycle, oled_clk=0, then return to IDLE.
REQ-022 oled_dc and oled_data SHALL hold their last values in IDLE; fb_addr SHALL return to 0.
REQ-023 start while busy SHALL be ignored; start in the DONE cycle SHALL be ignored; start in IDLE the cycle after DONE SHALL be accepted.
REQ-024 A frame SHALL take (FRAME_BYTES+1)*2*HALF cycles from CMD_LO entry to DONE entry.
REQ-025 cmd_byte changes after acceptance SHALL NOT affect the frame in progress.
REQ-026 Exactly FRAME_BYTES+1 oled_clk rising edges SHALL occur per frame.

Reset
REQ-027 Asserting reset_n=0 SHALL immediately force IDLE, oled_clk=0, oled_dc=0, oled_data=0, fb_addr=0, busy=0, done=0, phase and byte counters=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame without a done pulse; the first frame after release SHALL begin with a command byte.

Structure
REQ-029 The shared package SHALL hold the FSM state encoding, FRAME_BYTES=1024, and the address width constant (10).
REQ-030 One sub-module, oled_phase_timer (HALF-cycle down counter with terminal pulse), SHALL be instantiated; all other logic SHALL be in oled_frame_tx.

Verification
REQ-031 HALF=2, start with cmd_byte=8'hA5 -> first oled_clk rise at cycle 3 after start with dc=0, data=A5; 1025 rises; done at cycle 1+1025*4 after start.
REQ-032 Framebuffer model mem[i]=i[7:0] -> rising-edge capture sees dc=1, data 00,01,...,FF repeated 4 times, in order, none skipped.
REQ-033 Pulse start again at cycles 10 and 500 of a frame -> ignored; exactly one done.
REQ-034 Assert reset_n at data byte 300 -> all outputs zero at once, no done; start after release -> new frame begins with a command byte and address 0.
REQ-035 HALF=1, back-to-back start the cycle after done -> second frame accepted, gap-free, fb_addr never exceeds 1023.
REQ-036 Loopback into the existing VGA display block -> the display memory matches the framebuffer byte-for-byte after one frame.
